// File: rtl/timing_sequencer.sv
// Control-timing stage: start/stop flag S, sequence counter SC, one-hot T0..T(NUM_T-1)
// decode and a one-cycle wrap pulse that flags an instruction overrunning the last slot.
module timing_sequencer #(
  parameter int unsigned SC_WIDTH = 4,
  parameter int unsigned NUM_T    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                sc_clr,
  output logic [NUM_T-1:0]    t_out,
  output logic [SC_WIDTH-1:0] sc_value,
  output logic                running,
  output logic                t_wrap
);

  localparam logic [SC_WIDTH-1:0] SC_LAST = '1;
  localparam logic [SC_WIDTH-1:0] SC_ZERO = '0;
  localparam logic [SC_WIDTH-1:0] SC_ONE  = SC_WIDTH'(1);

  // The S flag is the FSM: idle (S=0) or running (S=1).
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SC_WIDTH-1:0] r_sc;
  logic [SC_WIDTH-1:0] w_sc_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;

  // State register: S, SC and the wrap pulse; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_sc    <= SC_ZERO;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state logic: halt beats start; SC advances only while running.
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_wrap_nxt  = 1'b0;
    if (halt) begin
      w_state_nxt = ST_IDLE;
      w_sc_nxt    = SC_ZERO;
    end else begin
      if (start) begin
        w_state_nxt = ST_RUN;
      end
      if (r_state == ST_RUN) begin
        if (sc_clr) begin
          w_sc_nxt = SC_ZERO;
        end else begin
          w_sc_nxt   = r_sc + SC_ONE;
          w_wrap_nxt = (r_sc == SC_LAST);
        end
      end
    end
  end

  // Output decode purely from registered state; no input reaches an output.
  always_comb begin
    t_out    = '0;
    running  = (r_state == ST_RUN);
    sc_value = r_sc;
    t_wrap   = r_wrap;
    if (r_state == ST_RUN) begin
      t_out = NUM_T'(1) << r_sc;
    end
  end

endmodule
